counter_sequencer: RTL

//  Run-control sequencer for the 8-bit lab counter: owns the prescaler and the count register and

---
 rtl/counter_sequencer_pkg.sv | 13 +
 rtl/counter_sequencer_tick_gen.sv | 33 +++
 rtl/counter_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the lab counter run-control sequencer.
package counter_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Prescaler for the counter sequencer: counts while enabled, strobes wrap on its last cycle.
module tick_gen #(
  parameter int DIV_COUNT = 5_000_000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV_COUNT - 1);

  logic [PW-1:0] presc_r;

  // Prescaler register; clr wins over en, and a disabled prescaler holds its value for pause/resume.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
    end else if (clr) begin
      presc_r <= {PW{1'b0}};
    end else if (en) begin
      presc_r <= (presc_r == LAST) ? {PW{1'b0}} : presc_r + PW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // The strobe marks the edge on which the prescaler wraps, so the step lands on that same edge.
  assign wrap = en && !clr && (presc_r == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer for the 8-bit lab counter: FSM, sampled mode/limit and the count datapath.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int DIV_COUNT = 5_000_000,
  parameter int WIDTH     = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_down,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] limit_r;
  logic             up_r;
  logic             reload_r;
  logic             tick_r;
  logic             busy_r;
  logic             done_r;

  logic             wrap_s;
  logic             presc_en_s;
  logic             presc_clr_s;
  logic             start_only_s;
  logic             terminal_s;
  logic [WIDTH-1:0] step_val_s;

  // A start that coincides with stop is treated as stop only.
  assign start_only_s = start && !stop;
  // The stop edge itself still advances the prescaler; the frozen value resumes after start.
  assign presc_en_s   = (state_r == ST_RUN) && !clear;
  assign presc_clr_s  = clear || (start_only_s && ((state_r == ST_IDLE) || (state_r == ST_DONE)));

  tick_gen #(
    .DIV_COUNT(DIV_COUNT)
  ) u_tick_gen (
    .clk_in(clk_in),
    .reset (reset),
    .en    (presc_en_s),
    .clr   (presc_clr_s),
    .wrap  (wrap_s)
  );

  // Next count value for a step and whether this step hits the terminal value.
  always_comb begin
    terminal_s = 1'b0;
    step_val_s = count_r;
    if (up_r) begin
      terminal_s = (count_r == limit_r);
      step_val_s = terminal_s ? {WIDTH{1'b0}} : count_r + WIDTH'(1);
    end else begin
      terminal_s = (count_r == {WIDTH{1'b0}});
      step_val_s = terminal_s ? limit_r : count_r - WIDTH'(1);
    end
  end

  // Run-control FSM with registered count, tick and status outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= {WIDTH{1'b0}};
      limit_r  <= {WIDTH{1'b0}};
      up_r     <= 1'b0;
      reload_r <= 1'b0;
      tick_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      if (clear) begin
        state_r <= ST_IDLE;
        count_r <= {WIDTH{1'b0}};
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (start_only_s) begin
              state_r  <= ST_RUN;
              busy_r   <= 1'b1;
              done_r   <= 1'b0;
              up_r     <= up_down;
              reload_r <= auto_reload;
              limit_r  <= limit;
              count_r  <= up_down ? {WIDTH{1'b0}} : limit;
            end else begin
              state_r <= state_r;
            end
          end
          ST_RUN: begin
            // A terminal step without reload ends the run even if stop arrives on the same edge.
            if (wrap_s && terminal_s && !reload_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              if (wrap_s) begin
                count_r <= step_val_s;
                tick_r  <= 1'b1;
              end else begin
                count_r <= count_r;
              end
              if (stop) begin
                state_r <= ST_PAUSE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= ST_RUN;
              end
            end
          end
          ST_PAUSE: begin
            if (start_only_s) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_PAUSE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_r;
  assign tick  = tick_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign state = state_r;

endmodule
